// File: rtl/sequential_multiplier.sv
// Iterative shift-add multiplier: one multiplier bit per clock, signed or unsigned by parameter.
// Result and one-cycle done strobe appear WORD_LENGTH+1 cycles after the accepted start.
module sequential_multiplier #(
    parameter int unsigned WORD_LENGTH = 16,
    parameter bit          SIGNED      = 1'b1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [WORD_LENGTH-1:0]     multiplicand,
    input  logic [WORD_LENGTH-1:0]     multiplier,
    output logic [2*WORD_LENGTH-1:0]   product,
    output logic                       ready,
    output logic                       done
);

    localparam int unsigned W  = WORD_LENGTH;
    localparam int unsigned CW = $clog2(WORD_LENGTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FINISH
    } state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    mag_a_q, mag_a_d;
    logic [W-1:0]    mag_b_q, mag_b_d;
    logic [2*W-1:0]  acc_q, acc_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            neg_q, neg_d;
    logic [2*W-1:0]  product_q, product_d;
    logic            done_q, done_d;

    logic            a_neg, b_neg;
    logic [2*W-1:0]  addend;

    assign a_neg  = SIGNED && multiplicand[W-1];
    assign b_neg  = SIGNED && multiplier[W-1];
    assign addend = {{W{1'b0}}, mag_a_q} << cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            mag_a_q   <= '0;
            mag_b_q   <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            neg_q     <= 1'b0;
            product_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            mag_a_q   <= mag_a_d;
            mag_b_q   <= mag_b_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            neg_q     <= neg_d;
            product_q <= product_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        mag_a_d   = mag_a_q;
        mag_b_d   = mag_b_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        neg_d     = neg_q;
        product_d = product_q;
        done_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    // Magnitude of -2^(W-1) wraps to 2^(W-1), still exact as unsigned.
                    mag_a_d = a_neg ? -multiplicand : multiplicand;
                    mag_b_d = b_neg ? -multiplier   : multiplier;
                    neg_d   = a_neg ^ b_neg;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (mag_b_q[0]) begin
                    acc_d = acc_q + addend;
                end
                mag_b_d = mag_b_q >> 1;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CW'(W - 1)) begin
                    state_d = FINISH;
                end
            end
            FINISH: begin
                product_d = neg_q ? -acc_q : acc_q;
                done_d    = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign product = product_q;
    assign done    = done_q;
    assign ready   = (state_q == IDLE);

endmodule

// File: tb/tb_sequential_multiplier.sv
// Directed-vector bench: an unsigned and a signed instance driven by shared stimulus.
module tb_sequential_multiplier;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] a_r, b_r;
    logic [31:0] product_u, product_s;
    logic        ready_u, ready_s, done_u, done_s;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sequential_multiplier #(.WORD_LENGTH(16), .SIGNED(1'b0)) dut_u (
        .clk(clk), .reset(reset), .start(start),
        .multiplicand(a_r), .multiplier(b_r),
        .product(product_u), .ready(ready_u), .done(done_u)
    );

    sequential_multiplier #(.WORD_LENGTH(16), .SIGNED(1'b1)) dut_s (
        .clk(clk), .reset(reset), .start(start),
        .multiplicand(a_r), .multiplier(b_r),
        .product(product_s), .ready(ready_s), .done(done_s)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start one operation, verify the fixed latency, then verify the done/result cycle.
    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic [31:0] exp_u, input logic [31:0] exp_s,
                          input bit use_u, input bit use_s,
                          input bit extra_starts, input bit wiggle_ops);
        logic early_done;
        early_done = 1'b0;
        a_r   = a;
        b_r   = b;
        start = 1'b1;
        tick();
        start = 1'b0;
        check_val({tag, "_ready_low"}, 32'(ready_s), 32'd0);
        for (int k = 1; k <= 16; k++) begin
            if (wiggle_ops && k == 2) begin
                a_r = 16'hA5A5;
                b_r = 16'h5A5A;
            end
            start = extra_starts && (k == 3 || k == 10);
            tick();
            start = 1'b0;
            early_done = early_done | done_s | done_u;
        end
        check_val({tag, "_no_early_done"}, 32'(early_done), 32'd0);
        check_val({tag, "_ready_finish"}, 32'(ready_s), 32'd0);
        tick();
        if (use_u) begin
            check_val({tag, "_done_u"}, 32'(done_u), 32'd1);
            check_val({tag, "_prod_u"}, product_u, exp_u);
        end
        if (use_s) begin
            check_val({tag, "_done_s"}, 32'(done_s), 32'd1);
            check_val({tag, "_prod_s"}, product_s, exp_s);
        end
        tick();
        check_val({tag, "_done_clear"}, 32'(done_s | done_u), 32'd0);
        check_val({tag, "_ready_back"}, 32'(ready_s & ready_u), 32'd1);
        if (use_s) begin
            check_val({tag, "_hold_s"}, product_s, exp_s);
        end
    endtask

    initial begin
        logic seen_done;
        reset = 1'b1;
        start = 1'b0;
        a_r   = '0;
        b_r   = '0;
        tick();
        tick();
        reset = 1'b0;
        tick();
        check_val("rst_product", product_s, 32'd0);
        check_val("rst_ready", 32'(ready_s), 32'd1);
        check_val("rst_done", 32'(done_s), 32'd0);

        // Unsigned max*max; the signed instance sees -1*-1.
        run_op("umax", 16'hFFFF, 16'hFFFF, 32'hFFFE0001, 32'h00000001, 1'b1, 1'b1, 1'b0, 1'b0);

        // Reset after five RUN iterations discards the operation.
        a_r   = 16'd1234;
        b_r   = 16'd5678;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        check_val("midrst_prod_u", product_u, 32'd0);
        check_val("midrst_prod_s", product_s, 32'd0);
        check_val("midrst_ready", 32'(ready_s & ready_u), 32'd1);
        check_val("midrst_done", 32'(done_s | done_u), 32'd0);
        seen_done = 1'b0;
        for (int k = 0; k < 25; k++) begin
            tick();
            seen_done = seen_done | done_s | done_u;
        end
        check_val("midrst_no_done", 32'(seen_done), 32'd0);

        run_op("smin_sq", 16'h8000, 16'h8000, 32'h40000000, 32'h40000000, 1'b0, 1'b1, 1'b0, 1'b0);
        run_op("smin_x1", 16'h8000, 16'h0001, 32'h00008000, 32'hFFFF8000, 1'b1, 1'b1, 1'b0, 1'b0);
        run_op("s7xm3",   16'h0007, 16'hFFFD, 32'h0006FFEB, 32'hFFFFFFEB, 1'b1, 1'b1, 1'b0, 1'b0);
        run_op("zero",    16'h0000, 16'h1234, 32'h00000000, 32'h00000000, 1'b1, 1'b1, 1'b0, 1'b0);
        run_op("ident",   16'h0001, 16'h8001, 32'h00008001, 32'hFFFF8001, 1'b1, 1'b1, 1'b0, 1'b0);
        run_op("ignore_start", 16'd100, 16'd200, 32'd20000, 32'd20000, 1'b1, 1'b1, 1'b1, 1'b0);
        run_op("op_change",    16'd300, 16'd400, 32'd120000, 32'd120000, 1'b1, 1'b1, 1'b0, 1'b1);

        // Back-to-back with start held: dones expected 17, 35 and 53 cycles after the first accept.
        a_r   = 16'd3;
        b_r   = 16'd4;
        start = 1'b1;
        tick();
        a_r = 16'hFFFB;
        b_r = 16'd6;
        for (int c = 1; c <= 56; c++) begin
            tick();
            if (c == 18) begin
                a_r = 16'd100;
                b_r = 16'd100;
            end
            if (c == 36) start = 1'b0;
            check_val($sformatf("b2b_done_c%0d", c), 32'(done_s),
                      32'((c == 17) || (c == 35) || (c == 53)));
            if (c == 17) check_val("b2b_p1", product_s, 32'd12);
            if (c == 30) check_val("b2b_hold1", product_s, 32'd12);
            if (c == 35) check_val("b2b_p2", product_s, 32'hFFFFFFE2);
            if (c == 50) check_val("b2b_hold2", product_s, 32'hFFFFFFE2);
            if (c == 53) check_val("b2b_p3", product_s, 32'd10000);
        end
        check_val("b2b_final_ready", 32'(ready_s), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
